serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes two WIDTH-bit operands DIGIT bits per clock. Each digit slice is a ripple chain of one-bit full-adder cells, and a carry register links successive digits. Intended for area-constrained datapaths where an N-bit result may take WIDTH/DIGIT cycles. Uses a start/busy/done handshake and reports carry and signed overflow.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
DIGIT, 1, bits added per cycle; must divide WIDTH exactly, otherwise elaboration fails
NDIG (derived), WIDTH/DIGIT, number of digit cycles per operation

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when not busy
sub  in  1  0 = add, 1 = subtract; latched with operands on start
a  in  WIDTH  operand A; latched on start
b  in  WIDTH  operand B; latched on start
c_in  in  1  carry-in for add, borrow-in for subtract; latched on start
busy  out  1  high while digits are being processed
done  out  1  one-cycle pulse when the result becomes valid
sum  out  WIDTH  result; held stable from done until the next accepted start
c_out  out  1  carry out of the MSB; for subtract, 1 = no borrow
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0; digit counter and shift registers cleared. Reset overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches operands.
  - Internal A register = a.
  - Internal B register = b when sub=0, ~b when sub=1.
  - Carry register = c_in when sub=0, ~c_in when sub=1. Subtract therefore computes a - b - c_in.
  - Counter=0; go to RUN; busy=1 from this edge.
- RUN: each edge adds the low DIGIT bits of A, B and carry.
  - The DIGIT-bit result shifts into sum from the MSB end.
  - A and B shift right by DIGIT; carry is updated; counter increments.
  - On the final digit (counter=NDIG-1), c_out and ovf are captured from that digit's MSB cell, state goes to DONE, busy=0, done=1.
- Latency: done is high exactly NDIG edges after the edge that accepted start.
- DONE: lasts one cycle; done=1; returns to IDLE. A start sampled in DONE is accepted exactly as in IDLE (back-to-back operation, no bubble).
- start while busy (RUN) is ignored and not queued. Operand/sub/c_in changes during RUN have no effect.
- sum, c_out and ovf hold their last completed values in IDLE. During RUN, sum shows partial shift contents and is only valid when done=1 or afterwards.
- Reset mid-operation aborts: no done pulse, all outputs zero on the next cycle; a new start is accepted after rst deasserts.
- All arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), helper for counter width (clog2(NDIG), min 1), NDIG derivation.
- One sub-module: digit_adder (combinational, DIGIT-bit ripple of full-adder cells). Inputs: x, y, cin. Outputs: s, cout, and c_msb_in (carry into the top cell, used for ovf).

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C c_in=0 -> done 8 cycles after start; sum=0x96, c_out=0, ovf=1.
- WIDTH=8, DIGIT=1, add a=0xFF b=0x01 c_in=0 -> sum=0x00, c_out=1, ovf=0. Then sub a=0x10 b=0x20 c_in=0 -> sum=0xF0, c_out=0, ovf=0.
- WIDTH=8, DIGIT=1, sub a=0x80 b=0x01 c_in=0 -> sum=0x7F, c_out=1, ovf=1. Pulse start again at cycle 3 while busy -> ignored; exactly one done pulse.
- WIDTH=8, DIGIT=4, add a=0xFF b=0x01 c_in=1 -> done 2 cycles after start; sum=0x01, c_out=1, ovf=0. Hold start high through DONE -> second operation starts with no idle cycle.
- Assert rst at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, c_out=0, ovf=0, no done pulse. Then add a=0x01 b=0x02 -> sum=0x03 after NDIG cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Holds the FSM encoding, the digit-count derivation and the full-adder cell function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles needed to cover a WIDTH-bit operand.
    function automatic int ndig_of(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-digit operation still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

    // One-bit full adder, returned as {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic s;
        logic co;
        s  = x ^ y ^ c;
        co = (x & y) | (c & (x ^ y));
        return {co, s};
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from one-bit full-adder cells.
// Exposes the carry into the top cell so the caller can derive signed overflow.
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry_chain;

    assign carry_chain[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            logic [1:0] cell_out;
            assign cell_out           = full_add(x[gi], y[gi], carry_chain[gi]);
            assign s[gi]              = cell_out[0];
            assign carry_chain[gi+1]  = cell_out[1];
        end
    endgenerate

    assign cout     = carry_chain[DIGIT];
    assign c_msb_in = carry_chain[DIGIT-1];

endmodule : digit_adder

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per clock,
// with a start/busy/done handshake and registered sum, carry-out and overflow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = ndig_of(WIDTH, DIGIT);
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH (>= 2) exactly");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_c_msb;
    logic [WIDTH-1:0] sum_next;
    logic             accept;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (a_reg[DIGIT-1:0]),
        .y        (b_reg[DIGIT-1:0]),
        .cin      (carry_reg),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_c_msb)
    );

    // Each digit result enters at the MSB end, so after NDIG shifts the
    // first digit has arrived at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_sum_whole
            assign sum_next = dig_s;
        end else begin : g_sum_shift
            assign sum_next = {dig_s, sum_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    // DONE accepts a new request just like IDLE so operations can run back to back.
    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        // Subtract is a + ~b + ~c_in, i.e. a - b - c_in.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= c_in ^ sub;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                RUN: begin
                    sum_reg   <= sum_next;
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    carry_reg <= dig_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_DIG) begin
                        c_out_reg <= dig_cout;
                        ovf_reg   <= dig_cout ^ dig_c_msb;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a bit-serial instance (DIGIT=1) and a
// nibble-serial instance (DIGIT=4), checked against hand-computed results.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       d1_start, d1_sub, d1_c_in;
    logic [7:0] d1_a, d1_b;
    logic       d1_busy, d1_done, d1_c_out, d1_ovf;
    logic [7:0] d1_sum;

    logic       d4_start, d4_sub, d4_c_in;
    logic [7:0] d4_a, d4_b;
    logic       d4_busy, d4_done, d4_c_out, d4_ovf;
    logic [7:0] d4_sum;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk   (clk),
        .rst   (rst),
        .start (d1_start),
        .sub   (d1_sub),
        .a     (d1_a),
        .b     (d1_b),
        .c_in  (d1_c_in),
        .busy  (d1_busy),
        .done  (d1_done),
        .sum   (d1_sum),
        .c_out (d1_c_out),
        .ovf   (d1_ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk   (clk),
        .rst   (rst),
        .start (d4_start),
        .sub   (d4_sub),
        .a     (d4_a),
        .b     (d4_b),
        .c_in  (d4_c_in),
        .busy  (d4_busy),
        .done  (d4_done),
        .sum   (d4_sum),
        .c_out (d4_c_out),
        .ovf   (d4_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation on the DIGIT=1 instance and return the number of
    // edges from acceptance to done (-1 if done never arrives).
    task automatic op_d1(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic c_in, output int lat);
        d1_a = a; d1_b = b; d1_sub = sub; d1_c_in = c_in; d1_start = 1'b1;
        step();
        d1_start = 1'b0;
        check("d1_busy_after_start", 32'(d1_busy), 32'd1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (d1_done) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int pulses;
    int first_done;

    initial begin
        rst = 1'b1;
        d1_start = 1'b0; d1_sub = 1'b0; d1_c_in = 1'b0; d1_a = '0; d1_b = '0;
        d4_start = 1'b0; d4_sub = 1'b0; d4_c_in = 1'b0; d4_a = '0; d4_b = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_d1_busy", 32'(d1_busy), 32'd0);
        check("reset_d1_done", 32'(d1_done), 32'd0);
        check("reset_d1_sum", 32'(d1_sum), 32'h00);
        check("reset_d1_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'd0);
        check("reset_d4_busy_done", {30'd0, d4_busy, d4_done}, 32'd0);

        // 0x5A + 0x3C = 0x96: no carry, positive + positive -> negative
        op_d1(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        $display("add 5A+3C lat=%0d sum=%h c=%b v=%b", lat, d1_sum, d1_c_out, d1_ovf);
        check("add1_latency", 32'(lat), 32'd8);
        check("add1_sum", 32'(d1_sum), 32'h96);
        check("add1_cout", 32'(d1_c_out), 32'd0);
        check("add1_ovf", 32'(d1_ovf), 32'd1);
        check("add1_busy_at_done", 32'(d1_busy), 32'd0);
        step();
        check("add1_done_one_cycle", 32'(d1_done), 32'd0);
        check("add1_sum_hold", 32'(d1_sum), 32'h96);

        // 0xFF + 0x01 wraps to 0x00 with carry out
        op_d1(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        $display("add FF+01 lat=%0d sum=%h c=%b v=%b", lat, d1_sum, d1_c_out, d1_ovf);
        check("add2_latency", 32'(lat), 32'd8);
        check("add2_sum", 32'(d1_sum), 32'h00);
        check("add2_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'b10);
        step();

        // 0x10 - 0x20 = 0xF0 with a borrow (c_out = 0)
        op_d1(8'h10, 8'h20, 1'b1, 1'b0, lat);
        $display("sub 10-20 lat=%0d sum=%h c=%b v=%b", lat, d1_sum, d1_c_out, d1_ovf);
        check("sub1_latency", 32'(lat), 32'd8);
        check("sub1_sum", 32'(d1_sum), 32'hF0);
        check("sub1_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'b00);
        step();

        // 0x80 - 0x01 = 0x7F: no borrow, signed overflow; a second start while busy is dropped
        d1_a = 8'h80; d1_b = 8'h01; d1_sub = 1'b1; d1_c_in = 1'b0; d1_start = 1'b1;
        step();
        d1_start = 1'b0;
        pulses = 0;
        first_done = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin
                d1_a = 8'h11; d1_b = 8'h22; d1_sub = 1'b0; d1_start = 1'b1;
            end
            step();
            d1_start = 1'b0;
            if (d1_done) begin
                pulses++;
                if (first_done == 0) first_done = i;
            end
        end
        $display("sub 80-01 with ignored start: done at %0d pulses=%0d sum=%h c=%b v=%b",
                 first_done, pulses, d1_sum, d1_c_out, d1_ovf);
        check("sub2_done_pulses", 32'(pulses), 32'd1);
        check("sub2_latency", 32'(first_done), 32'd8);
        check("sub2_sum", 32'(d1_sum), 32'h7F);
        check("sub2_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'b11);
        check("sub2_idle_after", 32'(d1_busy), 32'd0);

        // DIGIT=4: 0xFF + 0x01 + 1 = 0x101, then back-to-back 0x12 + 0x34
        d4_a = 8'hFF; d4_b = 8'h01; d4_sub = 1'b0; d4_c_in = 1'b1; d4_start = 1'b1;
        step();
        check("d4_busy_after_start", 32'(d4_busy), 32'd1);
        step();
        check("d4_no_done_early", 32'(d4_done), 32'd0);
        d4_a = 8'h12; d4_b = 8'h34; d4_c_in = 1'b0;
        step();
        $display("d4 add FF+01+1 done=%b sum=%h c=%b v=%b", d4_done, d4_sum, d4_c_out, d4_ovf);
        check("d4_op1_done_lat2", 32'(d4_done), 32'd1);
        check("d4_op1_sum", 32'(d4_sum), 32'h01);
        check("d4_op1_cout_ovf", {30'd0, d4_c_out, d4_ovf}, 32'b10);
        step();
        d4_start = 1'b0;
        check("d4_b2b_busy", 32'(d4_busy), 32'd1);
        check("d4_b2b_done_low", 32'(d4_done), 32'd0);
        step();
        step();
        $display("d4 add 12+34 done=%b sum=%h c=%b v=%b", d4_done, d4_sum, d4_c_out, d4_ovf);
        check("d4_op2_done", 32'(d4_done), 32'd1);
        check("d4_op2_sum", 32'(d4_sum), 32'h46);
        check("d4_op2_cout_ovf", {30'd0, d4_c_out, d4_ovf}, 32'b00);
        step();

        // Reset during RUN cycle 4 aborts the operation with no done pulse
        d1_a = 8'h77; d1_b = 8'h11; d1_sub = 1'b0; d1_c_in = 1'b0; d1_start = 1'b1;
        step();
        d1_start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset mid-run busy=%b done=%b sum=%h c=%b v=%b",
                 d1_busy, d1_done, d1_sum, d1_c_out, d1_ovf);
        check("abort_busy_done", {30'd0, d1_busy, d1_done}, 32'd0);
        check("abort_sum", 32'(d1_sum), 32'h00);
        check("abort_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (d1_done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        op_d1(8'h01, 8'h02, 1'b0, 1'b0, lat);
        $display("add 01+02 after abort lat=%0d sum=%h c=%b v=%b", lat, d1_sum, d1_c_out, d1_ovf);
        check("post_abort_latency", 32'(lat), 32'd8);
        check("post_abort_sum", 32'(d1_sum), 32'h03);
        check("post_abort_cout_ovf", {30'd0, d1_c_out, d1_ovf}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
